// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, validates the start bit,
// samples 8 data bits LSB-first at mid-bit and checks the stop bit.
module uart_rx #(
  parameter int unsigned BAUD_END = 5207,
  parameter int unsigned BAUD_M   = BAUD_END / 2,
  parameter int unsigned BIT_END  = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BAUD_W = 13;
  localparam int unsigned BIT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_done_q, rx_done_d;
  logic                frame_err_q, frame_err_d;
  logic                rx_busy_q, rx_busy_d;
  logic                rx_r1_q, rx_r2_q, rx_r3_q;

  logic                fall_c;
  logic                sample_c;
  logic                wrap_c;
  logic [2:0]          bit_idx_c;

  assign fall_c    = rx_r3_q & ~rx_r2_q;
  assign sample_c  = (baud_cnt_q == BAUD_W'(BAUD_M));
  assign wrap_c    = (baud_cnt_q == BAUD_W'(BAUD_END));
  assign bit_idx_c = 3'(bit_cnt_q - BIT_W'(1));

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
      rx_r1_q     <= 1'b1;
      rx_r2_q     <= 1'b1;
      rx_r3_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
      rx_r1_q     <= rs232_rx;
      rx_r2_q     <= rx_r1_q;
      rx_r3_q     <= rx_r2_q;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (state_q != IDLE) begin
      if (wrap_c) begin
        baud_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
      end else begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        // A line already low (break) never starts a frame; an edge is required
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (fall_c) state_d = START;
      end
      START: begin
        if (sample_c) state_d = rx_r2_q ? IDLE : DATA;
      end
      DATA: begin
        if (sample_c) begin
          shift_d[bit_idx_c] = rx_r2_q;
          if (bit_cnt_q == BIT_W'(BIT_END - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // Leave mid stop bit so a start edge right after it is not missed
        if (sample_c) begin
          if (rx_r2_q) begin
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule
